daq_gearbox_fifo: RTL and testbench
===================================

// Module: daq_gearbox_fifo
// PURPOSE
//  Single-clock, parametrised width-converting FIFO for the DAQ path. Wide sample words
//  (RATIO lanes of RD_WIDTH bits) are written from the acquisition logic and read out
//  one lane per read toward the byte-wide host interface. Adds lane-order selection,
//  occupancy count and almost-full/almost-empty thresholds.
// PARAMETERS
//  RD_WIDTH      8   read lane width in bits
//  RATIO         2   lanes per written word; WR_WIDTH = RD_WIDTH*RATIO; >= 2
//  ADDRESS_WIDTH 6   depth in words = 2**ADDRESS_WIDTH
//  AFULL_LEVEL   56  almost_full asserted when usedw >= AFULL_LEVEL
//  AEMPTY_LEVEL  4   almost_empty asserted when usedw <= AEMPTY_LEVEL
//  MSB_FIRST     1   1: lane 0 = data[WR_WIDTH-1 -: RD_WIDTH]; 0: lane 0 = data[RD_WIDTH-1:0]
// PORTS
//  clk          in   1                 single clock, all logic on posedge
//  rst_n        in   1                 asynchronous active-low reset
//  clear        in   1                 synchronous active-high flush
//  data         in   RD_WIDTH*RATIO    write word
//  wrreq        in   1                 write request
//  wrfull       out  1                 no free word
//  almost_full  out  1                 usedw >= AFULL_LEVEL
//  q            out  RD_WIDTH          current head lane (show-ahead)
//  rdreq        in   1                 pop one lane
//  rdempty      out  1                 no lane available
//  almost_empty out  1                 usedw <= AEMPTY_LEVEL
//  usedw        out  ADDRESS_WIDTH+1   words held, incl. partially read head word (0..2**ADDRESS_WIDTH)
// BEHAVIOUR
//  - Reset (rst_n low, async) and clear (sync): wptr=rptr=0, lane=0, usedw=0, rdempty=1,
//    wrfull=0, almost_empty=1, almost_full=(AFULL_LEVEL==0). Memory contents not cleared.
//    clear has priority over wrreq/rdreq in the same cycle.
//  - All status outputs are registered, updated from the next-state count.
//  - Write: wrreq & !wrfull at edge -> Mem[wptr]<=data, wptr++ (wraps mod depth).
//    wrreq while wrfull ignored, no state change.
//  - Read: q = lane `lane` of Mem[rptr], valid whenever rdempty=0; undefined while rdempty=1.
//    rdreq & !rdempty at edge -> lane++; on lane==RATIO-1: lane<=0, rptr++ (wraps), word freed.
//    rdreq while rdempty ignored.
//  - Latency: word written at edge N -> rdempty=0, q=lane 0 after edge N.
//  - usedw: +1 on accepted write, -1 on final-lane pop, unchanged when both same cycle.
//  - wrfull = (usedw==2**ADDRESS_WIDTH); rdempty = (usedw==0).
//  - Full + final-lane pop same cycle: write still rejected (wrfull gates), wrfull drops next cycle.
//  - Empty + write same cycle: rdreq ignored, word lands, rdempty drops next cycle.
// CONFIGURATION
//  DAQ_GEARBOX_FIFO_ERR_EN defined: adds outputs wr_ovf, rd_udf (1 bit each), sticky,
//   set on edge with wrreq&wrfull / rdreq&rdempty; cleared only by rst_n or clear.
//  Undefined: ports absent, overflow/underflow requests silently dropped.
// TESTING
//  1. Reset, write 16'hA1B2 (MSB_FIRST=1) -> next cycle rdempty=0, q=8'hA1, usedw=1;
//     rdreq -> q=8'hB2; rdreq -> rdempty=1, usedw=0.
//  2. Write 64 words with no reads -> wrfull=1 after 64th, usedw=64, almost_full from 56th;
//     65th write dropped; 128 pops return all lanes in order.
//  3. usedw=5, lane=1: wrreq and rdreq same cycle -> usedw stays 5, lane=0, rptr advances.
//  4. Stream 200 random words at 1 write per 2 cycles, reads every cycle -> pointers wrap,
//     output matches scoreboard, never full, rdempty toggles correctly.
//  5. 10 words held, lane=1: pulse clear -> next cycle usedw=0, rdempty=1, lane=0;
//     repeat with rst_n low mid-cycle -> outputs reset immediately, no clock needed.
//  6. ERR_EN: write when full -> wr_ovf=1 and stays until clear; pop when empty -> rd_udf=1;
//     rerun test 1 with MSB_FIRST=0 -> q=8'hB2 then 8'hA1.

Source files
------------

// File: rtl/daq_gearbox_fifo_if.sv
// daq_gearbox_fifo_if: handshake/status bundle for the width-converting DAQ FIFO
//  clear                sync flush (master -> fifo)
//  data, wrreq          write word and request (master -> fifo)
//  rdreq                pop one lane (master -> fifo)
//  q                    show-ahead head lane (fifo -> master)
//  wrfull, almost_full  write-side status (fifo -> master)
//  rdempty, almost_empty read-side status (fifo -> master)
//  usedw                words held, including a partially read head word
//  wr_ovf, rd_udf       sticky error flags, only with DAQ_GEARBOX_FIFO_ERR_EN defined
interface daq_gearbox_fifo_if #(
  parameter int RD_WIDTH      = 8,
  parameter int RATIO         = 2,
  parameter int ADDRESS_WIDTH = 6
);
  logic                        clear;
  logic [RD_WIDTH*RATIO-1:0]   data;
  logic                        wrreq;
  logic                        wrfull;
  logic                        almost_full;
  logic [RD_WIDTH-1:0]         q;
  logic                        rdreq;
  logic                        rdempty;
  logic                        almost_empty;
  logic [ADDRESS_WIDTH:0]      usedw;
`ifdef DAQ_GEARBOX_FIFO_ERR_EN
  logic                        wr_ovf;
  logic                        rd_udf;
  modport master (output clear, data, wrreq, rdreq,
                  input wrfull, almost_full, q, rdempty, almost_empty, usedw, wr_ovf, rd_udf);
  modport slave  (input clear, data, wrreq, rdreq,
                  output wrfull, almost_full, q, rdempty, almost_empty, usedw, wr_ovf, rd_udf);
`else
  modport master (output clear, data, wrreq, rdreq,
                  input wrfull, almost_full, q, rdempty, almost_empty, usedw);
  modport slave  (input clear, data, wrreq, rdreq,
                  output wrfull, almost_full, q, rdempty, almost_empty, usedw);
`endif
endinterface

// File: rtl/daq_gearbox_fifo.sv
// daq_gearbox_fifo: single-clock FIFO, RATIO-lane words in, one RD_WIDTH lane out per read
//  clk    single clock, posedge
//  rst_n  asynchronous active-low reset
//  bus    daq_gearbox_fifo_if.slave: clear, data/wrreq/wrfull/almost_full,
//         q/rdreq/rdempty/almost_empty, usedw
//  Optional: define DAQ_GEARBOX_FIFO_ERR_EN for sticky wr_ovf/rd_udf flags on the bus.
module daq_gearbox_fifo #(
  parameter int RD_WIDTH      = 8,
  parameter int RATIO         = 2,
  parameter int ADDRESS_WIDTH = 6,
  parameter int AFULL_LEVEL   = 56,
  parameter int AEMPTY_LEVEL  = 4,
  parameter int MSB_FIRST     = 1
) (
  input logic            clk,
  input logic            rst_n,
  daq_gearbox_fifo_if.slave bus
);
  localparam int WR_WIDTH = RD_WIDTH * RATIO;
  localparam int DEPTH    = 1 << ADDRESS_WIDTH;
  localparam int LW       = $clog2(RATIO);
  localparam logic [ADDRESS_WIDTH:0] FULL_CNT  = (ADDRESS_WIDTH+1)'(DEPTH);
  localparam logic [ADDRESS_WIDTH:0] AF_CNT    = (ADDRESS_WIDTH+1)'(AFULL_LEVEL);
  localparam logic [ADDRESS_WIDTH:0] AE_CNT    = (ADDRESS_WIDTH+1)'(AEMPTY_LEVEL);
  localparam logic [LW-1:0]          LAST_LANE = LW'(RATIO - 1);
  logic [WR_WIDTH-1:0]      mem [DEPTH];
  logic [ADDRESS_WIDTH-1:0] wptr, rptr;
  logic [LW-1:0]            lane, sel;
  logic [ADDRESS_WIDTH:0]   cnt, cnt_nxt;
  logic [WR_WIDTH-1:0]      word;
  logic                     do_wr, do_rd, last;
  assign do_wr   = bus.wrreq & ~bus.wrfull;
  assign do_rd   = bus.rdreq & ~bus.rdempty;
  // a word is only freed when its final lane is popped
  assign last    = do_rd & (lane == LAST_LANE);
  assign cnt_nxt = bus.clear ? '0 : cnt + {{ADDRESS_WIDTH{1'b0}}, do_wr} - {{ADDRESS_WIDTH{1'b0}}, last};
  assign bus.usedw = cnt;
  assign word  = mem[rptr];
  assign sel   = (MSB_FIRST != 0) ? LAST_LANE - lane : lane;
  assign bus.q = word[sel*RD_WIDTH +: RD_WIDTH];
  always_ff @(posedge clk)
    if (do_wr & ~bus.clear) mem[wptr] <= bus.data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr             <= '0;
      rptr             <= '0;
      lane             <= '0;
      cnt              <= '0;
      bus.wrfull       <= 1'b0;
      bus.rdempty      <= 1'b1;
      bus.almost_empty <= 1'b1;
      bus.almost_full  <= (AFULL_LEVEL == 0);
    end else begin
      cnt              <= cnt_nxt;
      bus.wrfull       <= cnt_nxt == FULL_CNT;
      bus.rdempty      <= cnt_nxt == '0;
      bus.almost_full  <= cnt_nxt >= AF_CNT;
      bus.almost_empty <= cnt_nxt <= AE_CNT;
      if (bus.clear) begin
        wptr <= '0;
        rptr <= '0;
        lane <= '0;
      end else begin
        if (do_wr) wptr <= wptr + 1'b1;
        if (do_rd) lane <= last ? '0 : lane + 1'b1;
        if (last)  rptr <= rptr + 1'b1;
      end
    end
  end
`ifdef DAQ_GEARBOX_FIFO_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_ovf <= 1'b0;
      bus.rd_udf <= 1'b0;
    end else if (bus.clear) begin
      bus.wr_ovf <= 1'b0;
      bus.rd_udf <= 1'b0;
    end else begin
      if (bus.wrreq & bus.wrfull)  bus.wr_ovf <= 1'b1;
      if (bus.rdreq & bus.rdempty) bus.rd_udf <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_daq_gearbox_fifo.sv
// tb_daq_gearbox_fifo: scoreboard bench for daq_gearbox_fifo (MSB-first and LSB-first instances)
module tb_daq_gearbox_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  daq_gearbox_fifo_if #(.RD_WIDTH(8), .RATIO(2), .ADDRESS_WIDTH(6)) bus ();
  daq_gearbox_fifo_if #(.RD_WIDTH(8), .RATIO(2), .ADDRESS_WIDTH(6)) bus0 ();
  daq_gearbox_fifo #(.RD_WIDTH(8), .RATIO(2), .ADDRESS_WIDTH(6), .AFULL_LEVEL(56), .AEMPTY_LEVEL(4), .MSB_FIRST(1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  daq_gearbox_fifo #(.RD_WIDTH(8), .RATIO(2), .ADDRESS_WIDTH(6), .AFULL_LEVEL(56), .AEMPTY_LEVEL(4), .MSB_FIRST(0))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  int checks = 0;
  int fails = 0;
  logic [7:0] sb[$];
  int mcnt = 0;
  int mlane = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    sb.delete();
    mcnt = 0;
    mlane = 0;
  endtask

  // drives one cycle on the MSB-first FIFO and advances the reference model
  task automatic cycle(input logic wr, input logic [15:0] d, input logic rd);
    bit aw, ar;
    aw = wr && (mcnt < 64);
    ar = rd && (mcnt > 0);
    bus.wrreq = wr;
    bus.data  = d;
    bus.rdreq = rd;
    step();
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    if (ar) begin
      void'(sb.pop_front());
      if (mlane == 1) begin mlane = 0; mcnt--; end else mlane++;
    end
    if (aw) begin
      sb.push_back(d[15:8]);
      sb.push_back(d[7:0]);
      mcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.rdempty !== 1'b1) begin fails++; $display("FAIL reset_rdempty got=%b exp=1", bus.rdempty); end
    checks++; if (bus.wrfull !== 1'b0) begin fails++; $display("FAIL reset_wrfull got=%b exp=0", bus.wrfull); end
    checks++; if (bus.usedw !== 7'd0) begin fails++; $display("FAIL reset_usedw got=%0d exp=0", bus.usedw); end
    checks++; if (bus.almost_empty !== 1'b1) begin fails++; $display("FAIL reset_aempty got=%b exp=1", bus.almost_empty); end
    checks++; if (bus.almost_full !== 1'b0) begin fails++; $display("FAIL reset_afull got=%b exp=0", bus.almost_full); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic();
    cycle(1'b1, 16'hA1B2, 1'b0);
    checks++; if (bus.rdempty !== 1'b0) begin fails++; $display("FAIL basic_rdempty got=%b exp=0", bus.rdempty); end
    checks++; if (bus.q !== 8'hA1) begin fails++; $display("FAIL basic_q0 got=%h exp=a1", bus.q); end
    checks++; if (bus.usedw !== 7'd1) begin fails++; $display("FAIL basic_usedw got=%0d exp=1", bus.usedw); end
    cycle(1'b0, 16'h0, 1'b1);
    checks++; if (bus.q !== 8'hB2) begin fails++; $display("FAIL basic_q1 got=%h exp=b2", bus.q); end
    checks++; if (bus.usedw !== 7'd1) begin fails++; $display("FAIL basic_usedw_mid got=%0d exp=1", bus.usedw); end
    cycle(1'b0, 16'h0, 1'b1);
    checks++; if (bus.rdempty !== 1'b1) begin fails++; $display("FAIL basic_rdempty_end got=%b exp=1", bus.rdempty); end
    checks++; if (bus.usedw !== 7'd0) begin fails++; $display("FAIL basic_usedw_end got=%0d exp=0", bus.usedw); end
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    for (int i = 1; i <= 64; i++) begin
      cycle(1'b1, {8'(i), 8'(8'hFF - i)}, 1'b0);
      checks++; if (bus.usedw !== 7'(i)) begin fails++; $display("FAIL fill_usedw i=%0d got=%0d exp=%0d", i, bus.usedw, i); end
      checks++; if (bus.almost_full !== (i >= 56)) begin fails++; $display("FAIL fill_afull i=%0d got=%b exp=%b", i, bus.almost_full, i >= 56); end
    end
    checks++; if (bus.wrfull !== 1'b1) begin fails++; $display("FAIL fill_wrfull got=%b exp=1", bus.wrfull); end
    cycle(1'b1, 16'hDEAD, 1'b0);
    checks++; if (bus.usedw !== 7'd64) begin fails++; $display("FAIL fill_drop_usedw got=%0d exp=64", bus.usedw); end
    for (int j = 0; j < 128; j++) begin
      exp = sb[0];
      checks++; if (bus.q !== exp) begin fails++; $display("FAIL fill_q j=%0d got=%h exp=%h", j, bus.q, exp); end
      cycle(1'b0, 16'h0, 1'b1);
      if (j == 1) begin
        checks++; if (bus.wrfull !== 1'b0) begin fails++; $display("FAIL fill_wrfull_drop got=%b exp=0", bus.wrfull); end
      end
    end
    checks++; if (bus.rdempty !== 1'b1) begin fails++; $display("FAIL fill_rdempty_end got=%b exp=1", bus.rdempty); end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp;
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h3000 + 16'(i * 16'h0101), 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    checks++; if (bus.usedw !== 7'd5) begin fails++; $display("FAIL simul_pre_usedw got=%0d exp=5", bus.usedw); end
    exp = sb[0];
    checks++; if (bus.q !== exp) begin fails++; $display("FAIL simul_pre_q got=%h exp=%h", bus.q, exp); end
    cycle(1'b1, 16'h1234, 1'b1);
    checks++; if (bus.usedw !== 7'd5) begin fails++; $display("FAIL simul_usedw got=%0d exp=5", bus.usedw); end
    exp = sb[0];
    checks++; if (bus.q !== exp) begin fails++; $display("FAIL simul_q got=%h exp=%h", bus.q, exp); end
    while (mcnt > 0) begin
      exp = sb[0];
      checks++; if (bus.q !== exp) begin fails++; $display("FAIL simul_drain got=%h exp=%h", bus.q, exp); end
      cycle(1'b0, 16'h0, 1'b1);
    end
  endtask

  task automatic test_back_to_back();
    int words;
    bit wr;
    logic [7:0] exp;
    words = 0;
    for (int c = 0; c < 420; c++) begin
      wr = (c % 2 == 0) && (words < 200);
      checks++; if (bus.usedw !== 7'(mcnt)) begin fails++; $display("FAIL stream_usedw c=%0d got=%0d exp=%0d", c, bus.usedw, mcnt); end
      checks++; if (bus.rdempty !== (mcnt == 0)) begin fails++; $display("FAIL stream_rdempty c=%0d got=%b exp=%b", c, bus.rdempty, mcnt == 0); end
      checks++; if (bus.wrfull !== 1'b0) begin fails++; $display("FAIL stream_wrfull c=%0d got=%b exp=0", c, bus.wrfull); end
      checks++; if (bus.almost_empty !== (mcnt <= 4)) begin fails++; $display("FAIL stream_aempty c=%0d got=%b", c, bus.almost_empty); end
      if (mcnt > 0) begin
        exp = sb[0];
        checks++; if (bus.q !== exp) begin fails++; $display("FAIL stream_q c=%0d got=%h exp=%h", c, bus.q, exp); end
      end
      cycle(wr, 16'($urandom), 1'b1);
      if (wr) words++;
    end
    checks++; if (bus.rdempty !== 1'b1) begin fails++; $display("FAIL stream_end_rdempty got=%b exp=1", bus.rdempty); end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'h5500 + 16'(i), 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    bus.clear = 1'b1;
    bus.wrreq = 1'b1;
    bus.rdreq = 1'b1;
    bus.data  = 16'hFFFF;
    step();
    bus.clear = 1'b0;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
    model_reset();
    checks++; if (bus.usedw !== 7'd0) begin fails++; $display("FAIL clear_usedw got=%0d exp=0", bus.usedw); end
    checks++; if (bus.rdempty !== 1'b1) begin fails++; $display("FAIL clear_rdempty got=%b exp=1", bus.rdempty); end
    checks++; if (bus.almost_empty !== 1'b1) begin fails++; $display("FAIL clear_aempty got=%b exp=1", bus.almost_empty); end
    cycle(1'b1, 16'hC3D4, 1'b0);
    checks++; if (bus.q !== 8'hC3) begin fails++; $display("FAIL clear_lane0 got=%h exp=c3", bus.q); end
    cycle(1'b0, 16'h0, 1'b1);
    checks++; if (bus.q !== 8'hD4) begin fails++; $display("FAIL clear_lane1 got=%h exp=d4", bus.q); end
    cycle(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'h6600 + 16'(i), 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.usedw !== 7'd0) begin fails++; $display("FAIL arst_usedw got=%0d exp=0", bus.usedw); end
    checks++; if (bus.rdempty !== 1'b1) begin fails++; $display("FAIL arst_rdempty got=%b exp=1", bus.rdempty); end
    #1;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 16'hE7F8, 1'b0);
    checks++; if (bus.q !== 8'hE7) begin fails++; $display("FAIL arst_lane0 got=%h exp=e7", bus.q); end
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
  endtask

  task automatic test_lane_order();
    bus0.data  = 16'hA1B2;
    bus0.wrreq = 1'b1;
    step();
    bus0.wrreq = 1'b0;
    checks++; if (bus0.q !== 8'hB2) begin fails++; $display("FAIL lsb_q0 got=%h exp=b2", bus0.q); end
    bus0.rdreq = 1'b1;
    step();
    checks++; if (bus0.q !== 8'hA1) begin fails++; $display("FAIL lsb_q1 got=%h exp=a1", bus0.q); end
    step();
    bus0.rdreq = 1'b0;
    checks++; if (bus0.rdempty !== 1'b1) begin fails++; $display("FAIL lsb_rdempty got=%b exp=1", bus0.rdempty); end
  endtask

`ifdef DAQ_GEARBOX_FIFO_ERR_EN
  task automatic test_errors();
    checks++; if (bus.wr_ovf !== 1'b0) begin fails++; $display("FAIL err_ovf_init got=%b exp=0", bus.wr_ovf); end
    checks++; if (bus.rd_udf !== 1'b0) begin fails++; $display("FAIL err_udf_init got=%b exp=0", bus.rd_udf); end
    for (int i = 0; i < 64; i++) cycle(1'b1, 16'(i), 1'b0);
    checks++; if (bus.wr_ovf !== 1'b0) begin fails++; $display("FAIL err_ovf_full got=%b exp=0", bus.wr_ovf); end
    cycle(1'b1, 16'hBEEF, 1'b0);
    checks++; if (bus.wr_ovf !== 1'b1) begin fails++; $display("FAIL err_ovf_set got=%b exp=1", bus.wr_ovf); end
    cycle(1'b0, 16'h0, 1'b1);
    cycle(1'b0, 16'h0, 1'b1);
    checks++; if (bus.wr_ovf !== 1'b1) begin fails++; $display("FAIL err_ovf_sticky got=%b exp=1", bus.wr_ovf); end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    model_reset();
    checks++; if (bus.wr_ovf !== 1'b0) begin fails++; $display("FAIL err_ovf_clear got=%b exp=0", bus.wr_ovf); end
    cycle(1'b0, 16'h0, 1'b1);
    checks++; if (bus.rd_udf !== 1'b1) begin fails++; $display("FAIL err_udf_set got=%b exp=1", bus.rd_udf); end
    step();
    checks++; if (bus.rd_udf !== 1'b1) begin fails++; $display("FAIL err_udf_sticky got=%b exp=1", bus.rd_udf); end
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    checks++; if (bus.rd_udf !== 1'b0) begin fails++; $display("FAIL err_udf_clear got=%b exp=0", bus.rd_udf); end
  endtask
`endif

  initial begin
    bus.clear = 1'b0;  bus.wrreq = 1'b0;  bus.rdreq = 1'b0;  bus.data = '0;
    bus0.clear = 1'b0; bus0.wrreq = 1'b0; bus0.rdreq = 1'b0; bus0.data = '0;
    test_reset();
    test_basic();
    test_fill();
    test_simultaneous();
    test_back_to_back();
    test_clear();
    test_lane_order();
`ifdef DAQ_GEARBOX_FIFO_ERR_EN
    test_errors();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
